// File: rtl/ast_width_reducer_pkg.sv
// Shared definitions for the Avalon-ST width reducer: FSM state encoding,
// test scenario tags and the byte/lane arithmetic used for eop words.
package ast_wr_package;

  // Scenario tags, used by the bench to label its report lines.
  typedef enum logic [1:0] {
    TEST_MVP,
    TEST_BACKPRESSURE,
    TEST_SHORT_PKT,
    TEST_RESET
  } test_case_e;

  // IDLE: buffer empty. SEND: buffer holds a word whose lanes are being emitted.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } wr_state_e;

  // Valid bytes carried by a wide word; only an eop word can be partial.
  function automatic int valid_bytes(input int ib, input int empty_in, input logic eop);
    return eop ? (ib - empty_in) : ib;
  endfunction

  // Narrow lanes needed to carry vbytes. Never returns less than one lane,
  // so an out-of-contract empty value cannot stall the FSM on a lane that
  // never matches the last-lane index.
  function automatic int lane_count(input int vbytes, input int ob);
    int n;
    n = (vbytes + ob - 1) / ob;
    return (n < 1) ? 1 : n;
  endfunction

  // Unused bytes at the top of the final narrow beat.
  function automatic int empty_bytes(input int lanes, input int vbytes, input int ob);
    return (lanes * ob) - vbytes;
  endfunction

endpackage

// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: splits each wide word into narrow beats, lane 0
// first, keeping sop/eop/channel and recomputing a byte-accurate empty.
//
// Handshake (both sides, readyLatency 0): a transfer happens on a rising
// clk edge where valid and ready are both high. valid never depends on
// ready; the beat and all its fields stay constant while valid_o=1 and
// ready_i=0. ast_ready_o depends combinationally on ast_ready_i so a new
// word can be loaded in the same cycle the last lane of the current one
// leaves, giving full output utilisation for back-to-back words.
module ast_width_reducer
  import ast_wr_package::*;
#(
  parameter int DATA_IN_W   = 256,
  parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) == 0) ? 1 : $clog2(DATA_IN_W / 8),
  parameter int CHANNEL_W   = 10,
  parameter int DATA_OUT_W  = 64,
  parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) == 0) ? 1 : $clog2(DATA_OUT_W / 8)
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  // wide input side
  input  logic [DATA_IN_W-1:0]   ast_data_i,
  input  logic                   ast_startofpacket_i,
  input  logic                   ast_endofpacket_i,
  input  logic                   ast_valid_i,
  input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
  input  logic [CHANNEL_W-1:0]   ast_channel_i,
  output logic                   ast_ready_o,
  // narrow output side
  output logic [DATA_OUT_W-1:0]  ast_data_o,
  output logic                   ast_startofpacket_o,
  output logic                   ast_endofpacket_o,
  output logic                   ast_valid_o,
  output logic [EMPTY_OUT_W-1:0] ast_empty_o,
  output logic [CHANNEL_W-1:0]   ast_channel_o,
  input  logic                   ast_ready_i,
  // debug view of the FSM
  output wr_state_e              dbg_state_o
);

  localparam int R      = DATA_IN_W / DATA_OUT_W;
  localparam int IB     = DATA_IN_W / 8;
  localparam int OB     = DATA_OUT_W / 8;
  localparam int LANE_W = (R > 1) ? $clog2(R) : 1;

  // FSM and lane pointer
  wr_state_e         state_q;
  wr_state_e         state_d;
  logic [LANE_W-1:0] lane_q;
  logic [LANE_W-1:0] lane_d;

  // One-word buffer. The lane count N is kept as its last index (N-1)
  // so the last-lane test is a plain equality.
  logic [DATA_IN_W-1:0]   buf_data_q;
  logic [CHANNEL_W-1:0]   buf_chan_q;
  logic                   buf_sop_q;
  logic                   buf_eop_q;
  logic [LANE_W-1:0]      buf_last_q;
  logic [EMPTY_OUT_W-1:0] buf_empty_q;

  // Lane geometry of the word on the input bus
  int                     in_vbytes;
  int                     in_lanes;
  int                     in_empty;
  logic [LANE_W-1:0]      in_last;
  logic [EMPTY_OUT_W-1:0] in_empty_out;

  logic last_lane;
  logic accept;

  assign last_lane   = (lane_q == buf_last_q);
  assign ast_ready_o = (state_q == ST_IDLE) || (last_lane && ast_ready_i);
  assign accept      = ast_valid_i && ast_ready_o;

  // Lane count and output empty of the incoming word; empty_i only matters on eop.
  always_comb begin
    in_vbytes    = valid_bytes(IB, int'(ast_empty_i), ast_endofpacket_i);
    in_lanes     = lane_count(in_vbytes, OB);
    in_empty     = empty_bytes(in_lanes, in_vbytes, OB);
    in_last      = LANE_W'(in_lanes - 1);
    in_empty_out = EMPTY_OUT_W'(in_empty);
  end

  // Next-state and lane-pointer logic.
  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_SEND;
          lane_d  = '0;
        end
      end
      ST_SEND: begin
        if (ast_ready_i) begin
          if (last_lane) begin
            // A word accepted alongside the last lane reloads the buffer
            // and keeps the output stream gap-free.
            lane_d  = '0;
            state_d = accept ? ST_SEND : ST_IDLE;
          end else begin
            lane_d = lane_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // State register; reset drops any partially sent word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
    end
  end

  // Word buffer, loaded on every accepted input word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      buf_data_q  <= '0;
      buf_chan_q  <= '0;
      buf_sop_q   <= 1'b0;
      buf_eop_q   <= 1'b0;
      buf_last_q  <= '0;
      buf_empty_q <= '0;
    end else if (accept) begin
      buf_data_q  <= ast_data_i;
      buf_chan_q  <= ast_channel_i;
      buf_sop_q   <= ast_startofpacket_i;
      buf_eop_q   <= ast_endofpacket_i;
      buf_last_q  <= in_last;
      buf_empty_q <= ast_endofpacket_i ? in_empty_out : '0;
    end
  end

  // Output beat: selected lane of the buffer plus per-beat framing.
  always_comb begin
    ast_valid_o         = (state_q == ST_SEND);
    ast_data_o          = buf_data_q[int'(lane_q) * DATA_OUT_W +: DATA_OUT_W];
    ast_channel_o       = buf_chan_q;
    ast_startofpacket_o = buf_sop_q && (lane_q == '0);
    ast_endofpacket_o   = buf_eop_q && last_lane;
    ast_empty_o         = (buf_eop_q && last_lane) ? buf_empty_q : '0;
  end

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ast_width_reducer.sv
// Self-checking bench for ast_width_reducer (256 -> 64 bit, channel 10).
module tb_ast_width_reducer;
  import ast_wr_package::*;

  localparam int DIN   = 256;
  localparam int DOUT  = 64;
  localparam int CW    = 10;
  localparam int EIW   = 5;
  localparam int EOW   = 3;
  localparam int IB    = 32;
  localparam int OB    = 8;
  // scoreboard entry: {last_lane, sop, eop, empty, channel, data}
  localparam int ENT_W = 3 + EOW + CW + DOUT;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n_i;
  logic [DIN-1:0]  ast_data_i;
  logic            ast_startofpacket_i;
  logic            ast_endofpacket_i;
  logic            ast_valid_i;
  logic [EIW-1:0]  ast_empty_i;
  logic [CW-1:0]   ast_channel_i;
  logic            ast_ready_o;
  logic [DOUT-1:0] ast_data_o;
  logic            ast_startofpacket_o;
  logic            ast_endofpacket_o;
  logic            ast_valid_o;
  logic [EOW-1:0]  ast_empty_o;
  logic [CW-1:0]   ast_channel_o;
  logic            ast_ready_i = 1'b1;
  wr_state_e       dbg_state_o;

  ast_width_reducer dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n_i),
    .ast_data_i          (ast_data_i),
    .ast_startofpacket_i (ast_startofpacket_i),
    .ast_endofpacket_i   (ast_endofpacket_i),
    .ast_valid_i         (ast_valid_i),
    .ast_empty_i         (ast_empty_i),
    .ast_channel_i       (ast_channel_i),
    .ast_ready_o         (ast_ready_o),
    .ast_data_o          (ast_data_o),
    .ast_startofpacket_o (ast_startofpacket_o),
    .ast_endofpacket_o   (ast_endofpacket_o),
    .ast_valid_o         (ast_valid_o),
    .ast_empty_o         (ast_empty_o),
    .ast_channel_o       (ast_channel_o),
    .ast_ready_i         (ast_ready_i),
    .dbg_state_o         (dbg_state_o)
  );

  // ---------------- bookkeeping ----------------
  int               checks = 0;
  int               errors = 0;
  logic [ENT_W-1:0] exp_q[$];
  int               beat_cnt = 0;
  int               pushed_cnt = 0;
  int               last_empty_seen = -1;
  int               gap_cnt = 0;
  bit               meas_en = 1'b0;
  bit               rand_ready = 1'b0;
  bit               ready_val = 1'b1;
  logic [CW-1:0]    prev_chan = '0;
  test_case_e       cur_test = TEST_MVP;

  // downstream ready: fixed level or 50% random, updated just after each edge
  always @(posedge clk) begin
    #1;
    ast_ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : ready_val;
  end

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [ENT_W-1:0] exp;
    logic [ENT_W-2:0] got;
    if (rst_n_i) begin
      if (ast_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL %s unexpected_beat got data=%h with empty expected queue", cur_test.name(), ast_data_o);
        end else begin
          exp = exp_q[0];
          checks++;
          if (ast_ready_o !== (exp[ENT_W-1] && ast_ready_i)) begin
            errors++;
            $display("FAIL %s ready_o_send got=%b expected=%b", cur_test.name(), ast_ready_o, exp[ENT_W-1] && ast_ready_i);
          end
          if (ast_ready_i) begin
            exp = exp_q.pop_front();
            got = {ast_startofpacket_o, ast_endofpacket_o, ast_empty_o, ast_channel_o, ast_data_o};
            checks++;
            if (got !== exp[ENT_W-2:0]) begin
              errors++;
              $display("FAIL %s beat got=%h expected=%h", cur_test.name(), got, exp[ENT_W-2:0]);
            end
            if (meas_en && !ast_startofpacket_o) begin
              checks++;
              if (ast_channel_o !== prev_chan) begin
                errors++;
                $display("FAIL %s chan_change_without_sop got=%0d expected=%0d", cur_test.name(), ast_channel_o, prev_chan);
              end
            end
            prev_chan = ast_channel_o;
            beat_cnt++;
            if (ast_endofpacket_o) last_empty_seen = int'(ast_empty_o);
          end
        end
      end else begin
        checks++;
        if (ast_ready_o !== 1'b1) begin
          errors++;
          $display("FAIL %s ready_o_idle got=%b expected=1", cur_test.name(), ast_ready_o);
        end
        if (meas_en) gap_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [DIN-1:0] rand_word();
    logic [DIN-1:0] w;
    for (int i = 0; i < DIN / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Expected narrow beats of one accepted wide word.
  task automatic push_word(input logic [DIN-1:0] d, input logic sop, input logic eop,
                           input int emp, input logic [CW-1:0] ch);
    int v, n, e;
    logic is_last, is_eop;
    v = eop ? (IB - emp) : IB;
    n = (v + OB - 1) / OB;
    for (int k = 0; k < n; k++) begin
      is_last = (k == n - 1);
      is_eop  = eop && is_last;
      e       = is_eop ? (n * OB - v) : 0;
      exp_q.push_back({is_last, sop && (k == 0), is_eop, EOW'(e), ch, d[k*DOUT +: DOUT]});
      pushed_cnt++;
    end
  endtask

  // Presents one word and returns just after the edge that accepted it.
  task automatic send_word(input logic [DIN-1:0] d, input logic sop, input logic eop,
                           input int emp, input logic [CW-1:0] ch);
    bit acc;
    acc = 1'b0;
    ast_data_i          = d;
    ast_startofpacket_i = sop;
    ast_endofpacket_i   = eop;
    ast_empty_i         = eop ? EIW'(emp) : EIW'($urandom_range(0, 31));
    ast_channel_i       = ch;
    ast_valid_i         = 1'b1;
    for (int w = 0; w < 1000 && !acc; w++) begin
      @(negedge clk);
      acc = ast_ready_o;
      if (acc) push_word(d, sop, eop, emp, ch);
      @(posedge clk);
      #1;
    end
    ast_valid_i = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL %s accept_timeout got ready_o=0 expected=1 within 1000 cycles", cur_test.name());
    end
  endtask

  task automatic send_packet(input int nwords, input int last_empty, input logic [CW-1:0] ch);
    for (int i = 0; i < nwords; i++)
      send_word(rand_word(), i == 0, i == nwords - 1, (i == nwords - 1) ? last_empty : 0, ch);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000; i++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
      #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout got %0d beats pending expected 0", cur_test.name(), exp_q.size());
    end
  endtask

  task automatic clear_counts();
    beat_cnt        = 0;
    pushed_cnt      = 0;
    last_empty_seen = -1;
  endtask

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      errors++;
      $display("FAIL %s %s got=%0d expected=%0d", cur_test.name(), name, got, expv);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cur_test = TEST_RESET;
    #12;
    checks++;
    if (ast_valid_o !== 1'b0 || ast_ready_o !== 1'b1 || ast_data_o !== '0 ||
        ast_startofpacket_o !== 1'b0 || ast_endofpacket_o !== 1'b0 ||
        ast_empty_o !== '0 || ast_channel_o !== '0 || dbg_state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL %s reset_outputs got v=%b r=%b d=%h s=%b e=%b em=%0d ch=%0d st=%0d expected v=0 r=1 others 0",
               cur_test.name(), ast_valid_o, ast_ready_o, ast_data_o, ast_startofpacket_o,
               ast_endofpacket_o, ast_empty_o, ast_channel_o, dbg_state_o);
    end
    @(negedge clk);
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mvp();
    cur_test = TEST_MVP;
    clear_counts();
    send_packet(3, 0, 10'd5);
    wait_drain();
    check_int("beat_count", beat_cnt, 12);
    check_int("eop_empty", last_empty_seen, 0);
  endtask

  task automatic test_short_pkt();
    logic [DIN-1:0] d;
    cur_test = TEST_SHORT_PKT;
    clear_counts();
    send_packet(2, 20, 10'd9);
    wait_drain();
    check_int("beat_count_2w", beat_cnt, 6);
    check_int("eop_empty_2w", last_empty_seen, 4);

    clear_counts();
    d = rand_word();
    send_word(d, 1'b1, 1'b1, 31, 10'd3);
    @(negedge clk);
    checks++;
    if (ast_valid_o !== 1'b1 || ast_startofpacket_o !== 1'b1 || ast_endofpacket_o !== 1'b1 ||
        ast_empty_o !== 3'd7 || ast_data_o !== d[63:0] || dbg_state_o !== ST_SEND) begin
      errors++;
      $display("FAIL %s single_beat got v=%b s=%b e=%b em=%0d d=%h st=%0d expected v=1 s=1 e=1 em=7 d=%h st=1",
               cur_test.name(), ast_valid_o, ast_startofpacket_o, ast_endofpacket_o,
               ast_empty_o, ast_data_o, dbg_state_o, d[63:0]);
    end
    wait_drain();
    check_int("beat_count_1w", beat_cnt, 1);
    check_int("eop_empty_1w", last_empty_seen, 7);
  endtask

  task automatic test_back_to_back();
    cur_test = TEST_MVP;
    clear_counts();
    gap_cnt = 0;
    for (int p = 1; p <= 3; p++) begin
      for (int w = 0; w < 2; w++) begin
        send_word(rand_word(), w == 0, w == 1, 0, CW'(p));
        if (p == 1 && w == 0) meas_en = 1'b1;
      end
    end
    wait_drain();
    meas_en = 1'b0;
    check_int("idle_gaps", gap_cnt, 0);
    check_int("beat_count_b2b", beat_cnt, 24);
  endtask

  task automatic test_backpressure();
    cur_test = TEST_BACKPRESSURE;
    clear_counts();
    rand_ready = 1'b1;
    for (int p = 0; p < 100; p++) begin
      send_packet($urandom_range(1, 3), $urandom_range(0, 31), CW'($urandom_range(0, 1023)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    ready_val  = 1'b1;
    check_int("beat_count_rand", beat_cnt, pushed_cnt);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    cur_test = TEST_RESET;
    clear_counts();
    send_word(rand_word(), 1'b1, 1'b0, 0, 10'd6);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n_i = 1'b0;
    #1;
    checks++;
    if (ast_valid_o !== 1'b0 || ast_ready_o !== 1'b1 || dbg_state_o !== ST_IDLE) begin
      errors++;
      $display("FAIL %s mid_reset got v=%b r=%b st=%0d expected v=0 r=1 st=0",
               cur_test.name(), ast_valid_o, ast_ready_o, dbg_state_o);
    end
    exp_q.delete();
    #10;
    @(negedge clk);
    rst_n_i = 1'b1;
    @(posedge clk);
    #1;
    clear_counts();
    send_packet(2, 3, 10'd7);
    wait_drain();
    check_int("beat_count_after_reset", beat_cnt, 8);
    check_int("eop_empty_after_reset", last_empty_seen, 3);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst_n_i             = 1'b0;
    ast_data_i          = '0;
    ast_startofpacket_i = 1'b0;
    ast_endofpacket_i   = 1'b0;
    ast_valid_i         = 1'b0;
    ast_empty_i         = '0;
    ast_channel_i       = '0;
    test_reset();
    test_mvp();
    test_short_pkt();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
